// File: rtl/fetch_xlate_stage_if.sv
// Bundled PC-generator, MMU instruction-port, I-cache and replay signals for fetch_xlate_stage.
// The stage connects through the slave modport; its environment uses master.
interface fetch_xlate_stage_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_vaddr;
  logic [31:0] mmu_vaddr;
  logic        mmu_en;
  logic [31:0] mmu_paddr;
  logic        mmu_uncached;
  logic        mmu_miss;
  logic        mmu_illegal;
  logic        mmu_tlb_invalid;
  logic        tlb_write;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_vaddr;
  logic [31:0] out_paddr;
  logic        out_uncached;
  logic        out_exc;
  logic [4:0]  out_exccode;
  logic        out_refill;
  logic        replay_valid;
  logic [31:0] replay_vaddr;

  modport slave (
    input  req_valid, req_vaddr, mmu_paddr, mmu_uncached, mmu_miss, mmu_illegal,
           mmu_tlb_invalid, tlb_write, flush, out_ready,
    output req_ready, mmu_vaddr, mmu_en, out_valid, out_vaddr, out_paddr, out_uncached,
           out_exc, out_exccode, out_refill, replay_valid, replay_vaddr
  );

  modport master (
    output req_valid, req_vaddr, mmu_paddr, mmu_uncached, mmu_miss, mmu_illegal,
           mmu_tlb_invalid, tlb_write, flush, out_ready,
    input  req_ready, mmu_vaddr, mmu_en, out_valid, out_vaddr, out_paddr, out_uncached,
           out_exc, out_exccode, out_refill, replay_valid, replay_vaddr
  );
endinterface

// File: rtl/fetch_xlate_stage.sv
// Instruction-fetch translation stage: samples the MMU in the accept cycle, queues the result
// in a 2-entry FIFO for the I-cache, and holds issue after a faulting fetch until flush.
module fetch_xlate_stage #(
  parameter logic [4:0] EXC_ADEL = 5'h04,
  parameter logic [4:0] EXC_TLBL = 5'h02
) (
  input logic clk,
  input logic rst,
  fetch_xlate_stage_if.slave io
);

  typedef enum logic {ST_RUN = 1'b0, ST_EXC_HOLD = 1'b1} state_e;

  typedef struct packed {
    logic [31:0] vaddr;
    logic [31:0] paddr;
    logic        uncached;
    logic        exc;
    logic [4:0]  exccode;
    logic        refill;
  } entry_t;

  state_e            state_q, state_d;
  entry_t [1:0]      fifo_q, fifo_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              replay_valid_q, replay_valid_d;
  logic [31:0]       replay_vaddr_q, replay_vaddr_d;

  logic   accept, pop, out_valid;
  entry_t new_entry, head;

  assign out_valid    = (count_q != 2'd0);
  assign io.req_ready = (count_q < 2'd2) && (state_q == ST_RUN) && !io.flush && !io.tlb_write;
  assign accept       = io.req_valid && io.req_ready;
  assign pop          = out_valid && io.out_ready;
  assign io.mmu_vaddr = io.req_vaddr;
  assign io.mmu_en    = accept;

  // Classification priority: address error beats refill beats invalid.
  always_comb begin
    new_entry          = '0;
    new_entry.vaddr    = io.req_vaddr;
    new_entry.paddr    = io.mmu_paddr;
    new_entry.uncached = io.mmu_uncached;
    if ((io.req_vaddr[1:0] != 2'b00) || io.mmu_illegal) begin
      new_entry.exc     = 1'b1;
      new_entry.exccode = EXC_ADEL;
    end else if (io.mmu_miss) begin
      new_entry.exc     = 1'b1;
      new_entry.exccode = EXC_TLBL;
      new_entry.refill  = 1'b1;
    end else if (io.mmu_tlb_invalid) begin
      new_entry.exc     = 1'b1;
      new_entry.exccode = EXC_TLBL;
    end
  end

  always_comb begin
    state_d        = state_q;
    fifo_d         = fifo_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    count_d        = count_q;
    replay_valid_d = 1'b0;
    replay_vaddr_d = replay_vaddr_q;
    if (io.flush || io.tlb_write) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      state_d  = ST_RUN;
      // Replay the oldest translation the I-cache has not yet taken.
      if (!io.flush && count_q != 2'd0) begin
        if (!pop) begin
          replay_valid_d = 1'b1;
          replay_vaddr_d = fifo_q[rd_ptr_q].vaddr;
        end else if (count_q == 2'd2) begin
          replay_valid_d = 1'b1;
          replay_vaddr_d = fifo_q[~rd_ptr_q].vaddr;
        end
      end
    end else begin
      if (accept) begin
        fifo_d[wr_ptr_q] = new_entry;
        wr_ptr_d         = ~wr_ptr_q;
        if (new_entry.exc) state_d = ST_EXC_HOLD;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, accept} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_RUN;
      fifo_q         <= '0;
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      count_q        <= 2'd0;
      replay_valid_q <= 1'b0;
      replay_vaddr_q <= '0;
    end else begin
      state_q        <= state_d;
      fifo_q         <= fifo_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      replay_valid_q <= replay_valid_d;
      replay_vaddr_q <= replay_vaddr_d;
    end
  end

  // Outputs are forced to zero whenever the FIFO is empty.
  assign head            = out_valid ? fifo_q[rd_ptr_q] : '0;
  assign io.out_valid    = out_valid;
  assign io.out_vaddr    = head.vaddr;
  assign io.out_paddr    = head.paddr;
  assign io.out_uncached = head.uncached;
  assign io.out_exc      = head.exc;
  assign io.out_exccode  = head.exccode;
  assign io.out_refill   = head.refill;
  assign io.replay_valid = replay_valid_q;
  assign io.replay_vaddr = replay_vaddr_q;

endmodule

// File: tb/tb_fetch_xlate_stage.sv
// Directed-vector bench for fetch_xlate_stage with hand-computed expectations.
module tb_fetch_xlate_stage;
  logic clk;
  logic rst;
  int unsigned n_vec;
  int unsigned n_err;

  fetch_xlate_stage_if bus ();

  fetch_xlate_stage #(.EXC_ADEL(5'h04), .EXC_TLBL(5'h02)) dut (
    .clk(clk),
    .rst(rst),
    .io (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] v, input logic [31:0] p, input logic unc);
    bus.req_valid    = 1'b1;
    bus.req_vaddr    = v;
    bus.mmu_paddr    = p;
    bus.mmu_uncached = unc;
  endtask

  task automatic flags(input logic miss, input logic ill, input logic inv);
    bus.mmu_miss        = miss;
    bus.mmu_illegal     = ill;
    bus.mmu_tlb_invalid = inv;
  endtask

  task automatic do_flush();
    bus.req_valid = 1'b0;
    bus.flush     = 1'b1;
    cyc();
    bus.flush     = 1'b0;
  endtask

  task automatic fill_two();
    bus.out_ready = 1'b0;
    flags(1'b0, 1'b0, 1'b0);
    offer(32'h8000_1000, 32'h0000_1000, 1'b0);
    cyc();
    offer(32'h8000_1004, 32'h0000_1004, 1'b0);
    cyc();
    bus.req_valid = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_vaddr = '0; bus.mmu_paddr = '0; bus.mmu_uncached = 1'b0;
    flags(1'b0, 1'b0, 1'b0);
    bus.tlb_write = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    cyc();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_vaddr", bus.out_vaddr, 0);
    chk("rst_out_exccode", bus.out_exccode, 0);
    chk("rst_replay_valid", bus.replay_valid, 0);
    chk("rst_replay_vaddr", bus.replay_vaddr, 0);
    rst = 1'b0;
    cyc();

    // Streaming with out_ready held high
    bus.out_ready = 1'b1;
    offer(32'hBFC0_0000, 32'h1FC0_0000, 1'b0);
    #1;
    chk("s_req_ready", bus.req_ready, 1);
    chk("s_mmu_en", bus.mmu_en, 1);
    chk("s_mmu_vaddr", bus.mmu_vaddr, 32'hBFC0_0000);
    cyc();
    chk("s_valid0", bus.out_valid, 1);
    chk("s_vaddr0", bus.out_vaddr, 32'hBFC0_0000);
    chk("s_paddr0", bus.out_paddr, 32'h1FC0_0000);
    chk("s_exc0", bus.out_exc, 0);
    offer(32'hBFC0_0004, 32'h1FC0_0004, 1'b1);
    cyc();
    chk("s_valid1", bus.out_valid, 1);
    chk("s_paddr1", bus.out_paddr, 32'h1FC0_0004);
    chk("s_unc1", bus.out_uncached, 1);
    bus.req_valid = 1'b0;
    cyc();
    chk("s_drained", bus.out_valid, 0);

    // Backpressure: two accepted, third waits for a pop
    bus.out_ready = 1'b0;
    offer(32'h0000_1000, 32'h0000_A000, 1'b0);
    cyc();
    offer(32'h0000_1004, 32'h0000_A004, 1'b0);
    cyc();
    offer(32'h0000_1008, 32'h0000_A008, 1'b0);
    #1;
    chk("bp_full_ready", bus.req_ready, 0);
    cyc();
    chk("bp_head_a", bus.out_vaddr, 32'h0000_1000);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_ready_indep", bus.req_ready, 0);
    cyc();
    chk("bp_head_b", bus.out_vaddr, 32'h0000_1004);
    chk("bp_ready_c", bus.req_ready, 1);
    cyc();
    chk("bp_head_c", bus.out_vaddr, 32'h0000_1008);
    chk("bp_paddr_c", bus.out_paddr, 32'h0000_A008);
    bus.req_valid = 1'b0;
    cyc();
    chk("bp_empty", bus.out_valid, 0);

    // Exception classification and issue hold
    bus.out_ready = 1'b0;
    offer(32'h0040_0002, 32'h0040_0002, 1'b0);
    cyc();
    chk("adel_exc", bus.out_exc, 1);
    chk("adel_code", bus.out_exccode, 5'h04);
    chk("adel_refill", bus.out_refill, 0);
    chk("adel_paddr", bus.out_paddr, 32'h0040_0002);
    offer(32'h0040_0000, 32'h0040_0000, 1'b0);
    #1;
    chk("hold_ready0", bus.req_ready, 0);
    cyc();
    chk("hold_ready1", bus.req_ready, 0);
    chk("hold_valid", bus.out_valid, 1);
    do_flush();
    chk("flush_valid", bus.out_valid, 0);
    chk("flush_code", bus.out_exccode, 0);
    chk("flush_exc", bus.out_exc, 0);

    flags(1'b1, 1'b0, 1'b0);
    offer(32'h0040_0000, 32'h0050_0000, 1'b0);
    #1;
    chk("post_flush_ready", bus.req_ready, 1);
    cyc();
    chk("miss_code", bus.out_exccode, 5'h02);
    chk("miss_refill", bus.out_refill, 1);
    do_flush();

    flags(1'b0, 1'b0, 1'b1);
    offer(32'h0040_0000, 32'h0050_0000, 1'b0);
    cyc();
    chk("inv_code", bus.out_exccode, 5'h02);
    chk("inv_refill", bus.out_refill, 0);
    do_flush();

    flags(1'b1, 1'b1, 1'b0);
    offer(32'h0040_0000, 32'h0050_0000, 1'b0);
    cyc();
    chk("ill_code", bus.out_exccode, 5'h04);
    chk("ill_refill", bus.out_refill, 0);
    do_flush();
    flags(1'b0, 1'b0, 1'b0);

    // TLB write replays the head
    fill_two();
    bus.tlb_write = 1'b1;
    #1;
    chk("tlbw_ready", bus.req_ready, 0);
    cyc();
    bus.tlb_write = 1'b0;
    chk("tlbw_replay", bus.replay_valid, 1);
    chk("tlbw_rvaddr", bus.replay_vaddr, 32'h8000_1000);
    chk("tlbw_valid", bus.out_valid, 0);
    cyc();
    chk("tlbw_pulse", bus.replay_valid, 0);

    // flush wins over tlb_write
    fill_two();
    bus.tlb_write = 1'b1; bus.flush = 1'b1;
    cyc();
    bus.tlb_write = 1'b0; bus.flush = 1'b0;
    chk("tf_replay", bus.replay_valid, 0);
    chk("tf_valid", bus.out_valid, 0);

    // Head popped alongside tlb_write replays the second entry
    fill_two();
    bus.out_ready = 1'b1; bus.tlb_write = 1'b1;
    cyc();
    bus.tlb_write = 1'b0; bus.out_ready = 1'b0;
    chk("tp_replay", bus.replay_valid, 1);
    chk("tp_rvaddr", bus.replay_vaddr, 32'h8000_1004);

    // Empty FIFO: no replay
    bus.tlb_write = 1'b1;
    cyc();
    bus.tlb_write = 1'b0;
    chk("te_replay", bus.replay_valid, 0);

    // Asynchronous reset while full and holding
    offer(32'h0000_2000, 32'h0000_2000, 1'b0);
    cyc();
    offer(32'h0000_2006, 32'h0000_2006, 1'b0);
    cyc();
    #1;
    chk("pre_rst_hold", bus.req_ready, 0);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_vaddr", bus.out_vaddr, 0);
    cyc();
    rst = 1'b0;
    offer(32'h0000_3000, 32'h0000_3000, 1'b0);
    #1;
    chk("arst_ready", bus.req_ready, 1);
    bus.req_valid = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
